schoolbook_unload: RTL and testbench

Result-serializing stage that sits directly downstream of the schoolbook multiplier. It captures one full-width product on a single-cycle strobe and streams it out least-significant word first over a narrow valid/ready bus to the result FIFO or interconnect. The multiplier has no backpressure, so this block also flags any product that arrives while the previous one is still draining.

---
 rtl/schoolbook_pkg.sv | 9 +
 rtl/schoolbook_unload.sv | 76 +++++++
 tb/tb_schoolbook_unload.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/schoolbook_pkg.sv
// Shared constants and state encoding for the schoolbook multiplier result path.
package schoolbook_pkg;
  localparam int PW     = 384;
  localparam int WW     = 64;
  localparam int NWORDS = PW / WW;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/schoolbook_unload.sv
// Captures one full-width product on a strobe and streams it out LSW first over
// valid/ready; flags (sticky) any product that arrives while the previous one drains.
module schoolbook_unload #(
  parameter int PW = schoolbook_pkg::PW,
  parameter int WW = schoolbook_pkg::WW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [WW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          ovf
);
  import schoolbook_pkg::*;

  localparam int NW = PW / WW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  if (PW % WW != 0) begin : g_bad_width
    $error("schoolbook_unload: PW must be a multiple of WW");
  end

  state_t        state;
  logic [PW-1:0] hold;
  logic [IW-1:0] widx;

  // Indexed part-select, not a shifter, so the word stays put while stalled.
  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_last  = busy && (widx == LAST_IDX);
  assign out_data  = busy ? hold[int'(widx)*WW +: WW] : '0;
  assign in_ready  = (state == IDLE) || (out_last && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      widx  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (in_valid && !in_ready)
        ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            widx  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (widx == LAST_IDX) begin
              // Last word leaving: a product arriving now is taken back-to-back.
              if (in_valid) begin
                hold <= in_data;
                widx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_schoolbook_unload.sv
// Directed stimulus for schoolbook_unload with a queue scoreboard checked by a monitor.
module tb_schoolbook_unload;
  localparam int PW = 384;
  localparam int WW = 64;
  localparam int NW = PW / WW;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [PW-1:0] in_data;
  logic          in_ready, out_valid, out_last, busy, ovf;
  logic [WW-1:0] out_data;

  schoolbook_unload #(.PW(PW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   xfers = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [WW-1:0] base);
    logic [PW-1:0] p;
    for (int k = 0; k < NW; k++) p[k*WW +: WW] = base + WW'(k);
    return p;
  endfunction

  task automatic push(input logic [PW-1:0] p);
    exp_t e;
    for (int k = 0; k < NW; k++) begin
      e.d = p[k*WW +: WW];
      e.l = (k == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every transfer pops the scoreboard; stalls must hold data steady.
  logic          stall_prev = 1'b0;
  logic          rst_prev   = 1'b0;
  logic [WW-1:0] d_prev;
  logic          l_prev;
  always @(negedge clk) begin
    exp_t e;
    if (stall_prev && !rst_prev) begin
      chk("stall_valid", WW'(out_valid), WW'(1));
      chk("stall_data", out_data, d_prev);
      chk("stall_last", WW'(out_last), WW'(l_prev));
    end
    if (out_valid && out_ready && !rst) begin
      xfers++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_last", WW'(out_last), WW'(e.l));
      end
    end
    stall_prev = out_valid && !out_ready;
    rst_prev   = rst;
    d_prev     = out_data;
    l_prev     = out_last;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [PW-1:0] p, input bit accepted);
    in_valid = 1'b1;
    in_data  = p;
    if (accepted) push(p);
    tick();
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      out_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
      tick();
      i++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int x0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", WW'(out_valid), WW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", WW'(out_last), WW'(0));
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_ovf", WW'(ovf), WW'(0));
    chk("rst_in_ready", WW'(in_ready), WW'(1));
    rst = 1'b0;
    tick();

    // Basic drain
    out_ready = 1'b1;
    capture(mk(64'h1), 1'b1);
    chk("basic_busy", WW'(busy), WW'(1));
    drain(0, 20);
    chk("basic_busy_drop", WW'(busy), WW'(0));
    chk("basic_idle_valid", WW'(out_valid), WW'(0));

    // Backpressure
    out_ready = 1'b0;
    capture(mk(64'h11), 1'b1);
    chk("bp_in_ready_stalled", WW'(in_ready), WW'(0));
    drain(1, 40);

    // Back-to-back: B arrives on A's last-word transfer edge
    out_ready = 1'b1;
    capture(mk(64'h1), 1'b1);
    x0 = xfers;
    repeat (5) tick();
    chk("b2b_last", WW'(out_last), WW'(1));
    chk("b2b_in_ready", WW'(in_ready), WW'(1));
    capture(mk(64'hB0), 1'b1);
    repeat (6) tick();
    chk("b2b_xfers", WW'(xfers - x0), WW'(12));
    chk("b2b_ovf", WW'(ovf), WW'(0));
    chk("b2b_busy", WW'(busy), WW'(0));
    chk("b2b_left", WW'(exp_q.size()), WW'(0));

    // Overflow: product dropped during word 2 while stalled
    capture(mk(64'h21), 1'b1);
    tick(); tick();
    out_ready = 1'b0;
    chk("ovf_in_ready", WW'(in_ready), WW'(0));
    capture(mk(64'hC0), 1'b0);
    chk("ovf_set", WW'(ovf), WW'(1));
    drain(0, 20);
    repeat (3) tick();
    chk("ovf_sticky", WW'(ovf), WW'(1));
    chk("ovf_no_b", WW'(out_valid), WW'(0));

    // Reset mid-stream after word 3
    out_ready = 1'b1;
    capture(mk(64'h31), 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    chk("mrst_out_valid", WW'(out_valid), WW'(0));
    chk("mrst_busy", WW'(busy), WW'(0));
    chk("mrst_ovf", WW'(ovf), WW'(0));
    chk("mrst_in_ready", WW'(in_ready), WW'(1));
    chk("mrst_out_data", out_data, '0);
    rst = 1'b0;
    out_ready = 1'b1;
    capture(mk(64'h41), 1'b1);
    drain(0, 20);

    // Boundary values
    capture({PW{1'b1}}, 1'b1);
    drain(0, 20);
    capture({PW{1'b0}}, 1'b1);
    drain(0, 20);
    chk("end_ovf", WW'(ovf), WW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
